// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM ioctl port.
package nvram_pkg;

  // Arbitration / sweep states of the HPS side.
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    CLEAR
  } nvram_state_t;

  // ioctl_index value that addresses the NVRAM by default.
  localparam logic [7:0] NVRAM_INDEX_DEFAULT = 8'd4;

  // Byte written to every location by the power-up sweep.
  localparam logic [7:0] FILL_BYTE = 8'h00;

endpackage

// File: rtl/nvram_ioctl_port_spram.sv
// Single-port synchronous NVRAM array: 1-cycle read latency, read-before-write.
module nvram_spram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_sys,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic [7:0]        q
);

  logic [7:0] mem [0:(2**ADDR_W)-1];

  // One access per enabled cycle; q returns the byte held before any write.
  always_ff @(posedge clk_sys) begin
    if (en) begin
      if (we) mem[addr] <= din;
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/nvram_ioctl_port.sv
// Game CMOS NVRAM shared between the game CPU and the HPS ioctl upload/download
// path. The CPU always owns the RAM port on its cpu_ce cycles; HPS accesses are
// squeezed into free cycles and stalled with ioctl_wait.
// Optional build macro NVRAM_CLEAR_EN: after reset release, sweep 8'h00 into
// every location before any CPU or HPS access is served.
module nvram_ioctl_port
  import nvram_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter logic [7:0] NVRAM_INDEX = NVRAM_INDEX_DEFAULT,
  parameter logic [7:0] OOR_DATA    = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  input  logic              cpu_ce,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              dirty
);

  localparam logic [24:0] TOP_ADDR = 25'((2**ADDR_W) - 1);

  nvram_state_t      state_reg, state_next;
  logic              pending_reg, wait_reg;
  logic [7:0]        din_reg;
  logic [ADDR_W-1:0] hps_addr_reg;
  logic [7:0]        hps_data_reg;
  logic              hps_we_reg, hps_oor_reg;
  logic              dirty_reg, upload_d_reg, last_top_reg;
  logic              cpu_rd_d_reg;
  logic [7:0]        cpu_dout_reg;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din, ram_q;

  logic              sel, rd_req, wr_req, req_accept, addr_oor, cpu_ok, upload_fall;

`ifdef NVRAM_CLEAR_EN
  localparam nvram_state_t RESET_STATE = CLEAR;
  logic [ADDR_W-1:0] clr_cnt_reg;
  // The CPU is locked out while the sweep owns the RAM.
  assign cpu_ok = cpu_ce & (state_reg != CLEAR);
`else
  localparam nvram_state_t RESET_STATE = IDLE;
  assign cpu_ok = cpu_ce;
`endif

  assign sel         = (ioctl_index == NVRAM_INDEX);
  assign rd_req      = sel & ioctl_rd & ioctl_upload;
  assign wr_req      = sel & ioctl_wr & ioctl_download;
  // A strobe while one is still outstanding is a protocol error and is dropped.
  assign req_accept  = (rd_req | wr_req) & ~pending_reg;
  // Range check on the full 25-bit address, before truncation to ADDR_W.
  assign addr_oor    = (ioctl_addr >> ADDR_W) != 25'd0;
  assign upload_fall = upload_d_reg & ~ioctl_upload & sel;

  assign ioctl_din  = din_reg;
  assign ioctl_wait = wait_reg;
  assign dirty      = dirty_reg;
  // Fresh RAM data the cycle after a CPU read, then held until the next read.
  assign cpu_dout   = cpu_rd_d_reg ? ram_q : cpu_dout_reg;

  nvram_spram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_sys (clk_sys),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (ram_addr),
    .din     (ram_din),
    .q       (ram_q)
  );

  // Next-state and RAM port arbitration: sweep, then CPU, then HPS.
  always_comb begin
    state_next = state_reg;
    ram_en     = cpu_ok;
    ram_we     = cpu_ok & cpu_we;
    ram_addr   = cpu_addr;
    ram_din    = cpu_din;
    case (state_reg)
      IDLE: begin
        // The strobe cycle itself may already start the access.
        if ((pending_reg | req_accept) & ~cpu_ok) state_next = ACCESS;
      end
      ACCESS: begin
        if (!cpu_ok) begin
          ram_en     = ~hps_oor_reg;
          ram_we     = hps_we_reg;
          ram_addr   = hps_addr_reg;
          ram_din    = hps_data_reg;
          state_next = RESP;
        end
      end
      RESP: state_next = IDLE;
      CLEAR: begin
`ifdef NVRAM_CLEAR_EN
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_cnt_reg;
        ram_din  = FILL_BYTE;
        if (clr_cnt_reg == {ADDR_W{1'b1}}) state_next = IDLE;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_reg <= RESET_STATE;
    else          state_reg <= state_next;
  end

  // HPS request latch, stall flag and read response.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg  <= 1'b0;
      wait_reg     <= 1'b0;
      din_reg      <= 8'h00;
      hps_addr_reg <= '0;
      hps_data_reg <= 8'h00;
      hps_we_reg   <= 1'b0;
      hps_oor_reg  <= 1'b0;
    end else if (req_accept) begin
      pending_reg  <= 1'b1;
      wait_reg     <= 1'b1;
      hps_addr_reg <= ioctl_addr[ADDR_W-1:0];
      hps_data_reg <= ioctl_dout;
      hps_we_reg   <= wr_req;
      hps_oor_reg  <= addr_oor;
    end else if (state_reg == RESP) begin
      pending_reg <= 1'b0;
      wait_reg    <= 1'b0;
      if (!hps_we_reg) din_reg <= hps_oor_reg ? OOR_DATA : ram_q;
    end
  end

  // Dirty flag: set by CPU writes, cleared when an upload ends on the top address.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dirty_reg    <= 1'b0;
      upload_d_reg <= 1'b0;
      last_top_reg <= 1'b0;
    end else begin
      upload_d_reg <= ioctl_upload;
      if (req_accept & ~wr_req) last_top_reg <= (ioctl_addr == TOP_ADDR);
      else if (upload_fall)     last_top_reg <= 1'b0;
      if (cpu_ok & cpu_we)                dirty_reg <= 1'b1;
      else if (upload_fall & last_top_reg) dirty_reg <= 1'b0;
    end
  end

  // CPU read capture so cpu_dout survives later HPS accesses.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rd_d_reg <= 1'b0;
      cpu_dout_reg <= 8'h00;
    end else begin
      cpu_rd_d_reg <= cpu_ok & ~cpu_we;
      if (cpu_rd_d_reg) cpu_dout_reg <= ram_q;
    end
  end

`ifdef NVRAM_CLEAR_EN
  // Sweep address counter, one location per cycle while clearing.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                clr_cnt_reg <= '0;
    else if (state_reg == CLEAR) clr_cnt_reg <= clr_cnt_reg + 1'b1;
  end
`endif

endmodule

// File: doc/nvram_ioctl_port.md
Name: nvram_ioctl_port

Overview:
- Game-side CMOS NVRAM (high scores, bookkeeping) that the HPS can also read and write.
- Two directions on the HPS side:
  - Upload: read NVRAM and return bytes to the HPS via ioctl_rd/ioctl_din. This is the reverse of the ROM download path.
  - Download: restore a saved image via ioctl_wr.
- Owns one single-port RAM. Arbitrates each cycle between the game CPU (clock-enable driven) and HPS accesses, stalling the HPS with ioctl_wait.
- Sits in the top level beside the hps_io and mylstar board instances.

Parameters:
- ADDR_W, 8, NVRAM address width; depth = 2**ADDR_W bytes.
- NVRAM_INDEX, 8'd4, ioctl_index value that selects this block.
- OOR_DATA, 8'hFF, read data returned for an HPS address at or above the depth.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_upload  in  1  HPS upload in progress.
- ioctl_download  in  1  HPS download in progress.
- ioctl_index  in  8  transfer target index.
- ioctl_addr  in  25  HPS byte address.
- ioctl_rd  in  1  HPS read strobe, one cycle.
- ioctl_wr  in  1  HPS write strobe, one cycle.
- ioctl_dout  in  8  HPS write data.
- ioctl_din  out  8  HPS read data.
- ioctl_wait  out  1  stall request to HPS.
- cpu_ce  in  1  CPU access strobe; at most one every 2 cycles.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_we  in  1  CPU write, qualified by cpu_ce.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data.
- dirty  out  1  NVRAM changed by the CPU since the last complete upload.

Behaviour:
- Reset (reset_n=0, asynchronous) sets:
  - ioctl_din=0, ioctl_wait=0, cpu_dout=0, dirty=0.
  - FSM to IDLE, pending flags cleared.
- RAM contents are not reset.
- Select: sel = ioctl_index==NVRAM_INDEX.
  - HPS requests are ioctl_rd&ioctl_upload&sel, or ioctl_wr&ioctl_download&sel.
  - Strobes without sel are ignored; ioctl_wait stays 0.
- Request latch: an accepted strobe latches address and data, sets pending, and sets ioctl_wait=1 on the next cycle.
- CPU priority:
  - On a cpu_ce cycle the RAM port takes cpu_addr/cpu_we/cpu_din.
  - cpu_dout is registered and valid 1 cycle after cpu_ce; it holds until the next CPU read.
  - A CPU write with cpu_ce sets dirty.
- FSM states:
  - IDLE: pending & !cpu_ce -> ACCESS. Pending with cpu_ce waits one cycle.
  - ACCESS: drives the RAM with the HPS address and write enable -> RESP.
    - If the address is at or above the depth, no RAM access is made.
  - RESP:
    - Reads: ioctl_din <= RAM q, or OOR_DATA if out of range.
    - Clears pending, ioctl_wait <= 0 -> IDLE.
- HPS latency: minimum 3 cycles from strobe to ioctl_wait falling, plus 1 cycle for each colliding cpu_ce.
- A strobe arriving while pending=1 is a protocol error. It is dropped and pending data is unchanged.
- dirty clear: dirty clears on the falling edge of ioctl_upload with sel, but only if the last upload read reached address 2**ADDR_W-1. If a CPU write and the clear occur in the same cycle, the set wins.
- Transfer aborted (ioctl_upload/ioctl_download falls) while pending: the access still completes. No partial state remains.
- The HPS address is truncated to ADDR_W bits only after the range check.

Optional Feature:
- Macro: NVRAM_CLEAR_EN.
- Defined:
  - After reset release, a CLEAR state writes 8'h00 to all 2**ADDR_W locations, one per cycle, ignoring cpu_ce.
  - During the sweep: CPU writes are dropped, cpu_dout=0, and HPS requests are held with ioctl_wait=1 until the sweep completes.
  - A download arriving afterwards overwrites the cleared contents.
- Undefined: no CLEAR state; RAM power-up contents are undefined (simulation: X).

Decomposition:
- Package nvram_pkg:
  - FSM state enum {IDLE, ACCESS, RESP, CLEAR}.
  - Default NVRAM_INDEX.
  - Fill constant 8'h00.
- One sub-module, nvram_spram:
  - Single-port synchronous RAM, parameter ADDR_W.
  - Read-during-write returns old data.
  - 1-cycle read latency.

Test Plan:
- HPS write/read round trip: download with index 4, writes 0xA5 at addr 0x10, then upload reads addr 0x10 -> ioctl_din=0xA5 three cycles after ioctl_rd, and ioctl_wait pulses high for 2 cycles.
- Collision: ioctl_rd to addr 0x20 in the same cycle as a CPU write of 0x3C to 0x20 with cpu_ce -> HPS read returns 0x3C, ioctl_wait lasts 1 extra cycle, and dirty=1.
- Wrong index: ioctl_wr with index 0 -> no RAM change, ioctl_wait stays 0.
- Out of range: upload read at addr 0x100 with ADDR_W=8 -> ioctl_din=0xFF, RAM untouched.
- Dirty lifecycle:
  - CPU write -> dirty=1.
  - Full upload 0x00..0xFF, then ioctl_upload falls -> dirty=0.
  - Partial upload stopping at 0x7F -> dirty stays 1.
- Reset mid-access: reset_n low while in ACCESS -> ioctl_wait=0 and FSM IDLE immediately. With NVRAM_CLEAR_EN, all 256 locations read 0x00 after 256 cycles, and ioctl_wait stays high for an HPS read issued during the sweep.
